// File: rtl/imem_writer.sv
// Byte-stream loader for the instruction memory: assembles 30-bit words from a
// length-prefixed little-endian stream and holds the CPU in reset until loaded.
module imem_writer #(
  parameter int unsigned INSTR_W = 30,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               reload,
  output logic               we,
  output logic [ADDR_W-1:0]  waddr,
  output logic [INSTR_W-1:0] wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [15:0]        count
);

  localparam int unsigned LEN_W = 17;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          n_q, n_d;
  logic [23:0]          word_q, word_d;
  logic [1:0]           lane_q, lane_d;
  logic [15:0]          count_q, count_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    waddr_q, waddr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic                 in_ready_q, in_ready_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 accept_c;
  logic [15:0]          len_c;

  assign accept_c = in_valid && in_ready_q;
  assign len_c    = {in_data, n_q[7:0]};

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    word_d   = word_q;
    lane_d   = lane_q;
    count_d  = count_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    case (state_q)
      ST_LEN0: begin
        if (accept_c) begin
          n_d[7:0] = in_data;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept_c) begin
          n_d    = len_c;
          lane_d = 2'd0;
          if (len_c == 16'd0) begin
            state_d = ST_DONE;
          end else if (LEN_W'(len_c) > LEN_W'(DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (count_q == n_q) begin
          state_d = ST_DONE;
        end else if (accept_c) begin
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            default: begin
              if (in_data[7:6] != 2'b00) begin
                state_d = ST_ERR;
              end else begin
                we_d    = 1'b1;
                waddr_d = ADDR_W'(count_q);
                wdata_d = INSTR_W'({in_data[5:0], word_q});
                count_d = count_q + 16'd1;
              end
            end
          endcase
        end
      end
      ST_DONE, ST_ERR: begin
        if (reload) begin
          state_d = ST_LEN0;
          count_d = 16'd0;
          waddr_d = '0;
          lane_d  = 2'd0;
        end
      end
      default: state_d = ST_LEN0;
    endcase

    // Stop accepting once the final word is out; DONE follows next cycle.
    in_ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                 ((state_d == ST_DATA) && (count_d != n_d));
    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LEN0;
      n_q        <= 16'd0;
      word_q     <= 24'd0;
      lane_q     <= 2'd0;
      count_q    <= 16'd0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b1;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_q     <= word_d;
      lane_q     <= lane_d;
      count_q    <= count_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;
  assign count    = count_q;

endmodule

// File: tb/tb_imem_writer.sv
// Directed self-checking bench for imem_writer: normal, empty, oversize,
// bad-word, stalled, mid-word reset and reload loads.
module tb_imem_writer;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        we;
  logic [7:0]  waddr;
  logic [29:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] count;

  int checks;
  int failures;
  int nw;
  int base;
  logic [7:0]  log_addr [32];
  logic [29:0] log_data [32];

  imem_writer #(.INSTR_W(30), .DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .we(we), .waddr(waddr),
    .wdata(wdata), .cpu_hold(cpu_hold), .done(done), .err(err),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write logger: each we pulse lasts one cycle, so one negedge sees it once.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (nw < 32) begin
        log_addr[nw] = waddr;
        log_data[nw] = wdata;
      end
      nw = nw + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    int gap;
    gap = int'($urandom_range(0, 2));
    for (int i = 0; i < gap; i++) begin
      in_data = 8'hEE;
      @(posedge clk);
      #1;
    end
    send(b);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] words [4];
    checks   = 0;
    failures = 0;
    nw       = 0;
    rst      = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    reload   = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // N=2 load
    base = nw;
    send(8'h02); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    chk("n2_we_last", 32'(we), 32'd1);
    chk("n2_waddr_last", 32'(waddr), 32'd1);
    chk("n2_wdata_last", 32'(wdata), 32'h1);
    chk("n2_count", 32'(count), 32'd2);
    chk("n2_done_early", 32'(done), 32'd0);
    idle(1);
    chk("n2_done", 32'(done), 32'd1);
    chk("n2_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("n2_in_ready", 32'(in_ready), 32'd0);
    chk("n2_nwrites", 32'(nw - base), 32'd2);
    chk("n2_addr0", 32'(log_addr[base]), 32'd0);
    chk("n2_data0", 32'(log_data[base]), 32'h11223344);

    // Reload from DONE
    do_reload();
    chk("rl_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rl_count", 32'(count), 32'd0);
    chk("rl_done", 32'(done), 32'd0);
    chk("rl_in_ready", 32'(in_ready), 32'd1);

    // N=0 load
    base = nw;
    send(8'h00); send(8'h00);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("n0_count", 32'(count), 32'd0);
    chk("n0_nwrites", 32'(nw - base), 32'd0);

    // reload with a byte offered in the same cycle, then N=3 with bad 2nd word
    base     = nw;
    reload   = 1'b1;
    in_data  = 8'h03;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(8'h00);
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'h00); send(8'h00); send(8'h00); send(8'h40);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_we", 32'(we), 32'd0);
    chk("bad_count", 32'(count), 32'd1);
    chk("bad_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("bad_in_ready", 32'(in_ready), 32'd0);
    idle(2);
    chk("bad_err_sticky", 32'(err), 32'd1);
    chk("bad_nwrites", 32'(nw - base), 32'd1);
    chk("bad_addr0", 32'(log_addr[base]), 32'd0);
    chk("bad_data0", 32'(log_data[base]), 32'h1);

    // N=257 exceeds DEPTH
    do_reload();
    chk("rl2_err", 32'(err), 32'd0);
    base = nw;
    send(8'h01); send(8'h01);
    chk("big_err", 32'(err), 32'd1);
    chk("big_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("big_in_ready", 32'(in_ready), 32'd0);
    chk("big_nwrites", 32'(nw - base), 32'd0);

    // 4-word load with random in_valid gaps
    do_reload();
    words[0] = 32'h01020304;
    words[1] = 32'h3FFFFFFF;
    words[2] = 32'h00ABCDEF;
    words[3] = 32'h12345678;
    base = nw;
    send_gap(8'h04); send_gap(8'h00);
    for (int w = 0; w < 4; w++) begin
      logic [31:0] wv;
      wv = words[w];
      for (int b = 0; b < 4; b++) send_gap(wv[8*b +: 8]);
    end
    chk("gap_count", 32'(count), 32'd4);
    idle(1);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_nwrites", 32'(nw - base), 32'd4);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("gap_addr%0d", w), 32'(log_addr[base + w]), 32'(w));
      chk($sformatf("gap_data%0d", w), 32'(log_data[base + w]), words[w] & 32'h3FFFFFFF);
    end

    // Reset mid-word, then a clean 1-word load
    do_reload();
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    rst = 1'b0;
    #3;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    base = nw;
    send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    idle(1);
    chk("mr_done", 32'(done), 32'd1);
    chk("mr_nwrites", 32'(nw - base), 32'd1);
    chk("mr_addr", 32'(log_addr[base]), 32'd0);
    chk("mr_data", 32'(log_data[base]), 32'h12345678);

    // Reload from DONE restarts at address 0
    do_reload();
    chk("rl3_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rl3_count", 32'(count), 32'd0);
    base = nw;
    send(8'h01); send(8'h00);
    send(8'h05); send(8'h00); send(8'h00); send(8'h00);
    idle(1);
    chk("rl3_nwrites", 32'(nw - base), 32'd1);
    chk("rl3_addr", 32'(log_addr[base]), 32'd0);
    chk("rl3_data", 32'(log_data[base]), 32'h5);
    chk("rl3_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
